// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline controller: forwarding selects and
// the fetch-cancel state encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        C_IDLE   = 1'b0,
        C_CANCEL = 1'b1
    } cancel_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake/hazard bundle between the pipeline datapath (master) and the
// central pipeline controller (slave).
interface pipe_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              fs_valid;
    logic              fs_ready_go;
    logic [REG_AW-1:0] ds_rj;
    logic [REG_AW-1:0] ds_rk;
    logic              ds_use_rj;
    logic              ds_use_rk;
    logic              ds_br_taken;
    logic [REG_AW-1:0] es_dest;
    logic [REG_AW-1:0] ms_dest;
    logic [REG_AW-1:0] ws_dest;
    logic              es_gr_we;
    logic              ms_gr_we;
    logic              ws_gr_we;
    logic              es_load;
    logic              ms_load;
    logic              es_mem_req;
    logic              es_addr_ok;
    logic              ms_mem_req;
    logic              ms_data_ok;

    logic              fs_allowin;
    logic              ds_allowin;
    logic              es_allowin;
    logic              ms_allowin;
    logic              ds_valid;
    logic              es_valid;
    logic              ms_valid;
    logic              ws_valid;
    logic              fs2ds_en;
    logic              ds2es_en;
    logic              es2ms_en;
    logic              mem_ready_go;
    logic              br_flush;
    logic [1:0]        fwd_rj;
    logic [1:0]        fwd_rk;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output fs_valid, fs_ready_go, ds_rj, ds_rk, ds_use_rj, ds_use_rk, ds_br_taken,
               es_dest, ms_dest, ws_dest, es_gr_we, ms_gr_we, ws_gr_we,
               es_load, ms_load, es_mem_req, es_addr_ok, ms_mem_req, ms_data_ok,
        input  fs_allowin, ds_allowin, es_allowin, ms_allowin,
               ds_valid, es_valid, ms_valid, ws_valid,
               fs2ds_en, ds2es_en, es2ms_en, mem_ready_go,
               br_flush, fwd_rj, fwd_rk, stall_cnt, flush_cnt
    );

    modport slave (
        input  fs_valid, fs_ready_go, ds_rj, ds_rk, ds_use_rj, ds_use_rk, ds_br_taken,
               es_dest, ms_dest, ws_dest, es_gr_we, ms_gr_we, ws_gr_we,
               es_load, ms_load, es_mem_req, es_addr_ok, ms_mem_req, ms_data_ok,
        output fs_allowin, ds_allowin, es_allowin, ms_allowin,
               ds_valid, es_valid, ms_valid, ws_valid,
               fs2ds_en, ds2es_en, es2ms_en, mem_ready_go,
               br_flush, fwd_rj, fwd_rk, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_fwd_unit.sv
// Purely combinational ID-stage hazard detection and operand-forwarding select.
// A newer producer (EX) always shadows an older one (MEM, WB).
module hazard_fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ds_rj,
    input  logic [REG_AW-1:0] ds_rk,
    input  logic              ds_use_rj,
    input  logic              ds_use_rk,
    input  logic              es_valid,
    input  logic              es_gr_we,
    input  logic              es_load,
    input  logic [REG_AW-1:0] es_dest,
    input  logic              ms_valid,
    input  logic              ms_gr_we,
    input  logic              ms_load,
    input  logic              ms_data_ok,
    input  logic [REG_AW-1:0] ms_dest,
    input  logic              ws_valid,
    input  logic              ws_gr_we,
    input  logic [REG_AW-1:0] ws_dest,
    output logic              stall,
    output fwd_sel_t          fwd_rj,
    output fwd_sel_t          fwd_rk
);

    function automatic fwd_sel_t pick_src(input logic nz, input logic es_hit,
                                          input logic ms_hit, input logic ws_hit);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (!nz) begin
            sel = FWD_RF;
        end else if (es_hit) begin
            sel = FWD_EX;
        end else if (ms_hit) begin
            sel = FWD_MEM;
        end else if (ws_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    logic nz_j_s, nz_k_s;
    logic es_hit_j_s, ms_hit_j_s, ws_hit_j_s;
    logic es_hit_k_s, ms_hit_k_s, ws_hit_k_s;
    logic stall_j_s, stall_k_s;

    assign nz_j_s     = (ds_rj != {REG_AW{1'b0}});
    assign nz_k_s     = (ds_rk != {REG_AW{1'b0}});
    assign es_hit_j_s = es_valid & es_gr_we & (es_dest == ds_rj);
    assign ms_hit_j_s = ms_valid & ms_gr_we & (ms_dest == ds_rj);
    assign ws_hit_j_s = ws_valid & ws_gr_we & (ws_dest == ds_rj);
    assign es_hit_k_s = es_valid & es_gr_we & (es_dest == ds_rk);
    assign ms_hit_k_s = ms_valid & ms_gr_we & (ms_dest == ds_rk);
    assign ws_hit_k_s = ws_valid & ws_gr_we & (ws_dest == ds_rk);

    // A load result is unavailable while in EX, and in MEM until its data returns.
    assign stall_j_s = ds_use_rj & nz_j_s &
                       ((es_hit_j_s & es_load) | (ms_hit_j_s & ms_load & ~ms_data_ok));
    assign stall_k_s = ds_use_rk & nz_k_s &
                       ((es_hit_k_s & es_load) | (ms_hit_k_s & ms_load & ~ms_data_ok));
    assign stall     = stall_j_s | stall_k_s;

    assign fwd_rj = pick_src(nz_j_s, es_hit_j_s, ms_hit_j_s, ws_hit_j_s);
    assign fwd_rk = pick_src(nz_k_s, es_hit_k_s, ms_hit_k_s, ws_hit_k_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: stage valids, allowin chain, register
// load enables, branch flush with in-flight fetch cancellation, perf counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipe_ctrl_if.slave     bus
);

    logic             ds_valid_r, es_valid_r, ms_valid_r, ws_valid_r;
    cancel_state_t    cancel_state_r, cancel_state_s;
    logic             cancel_pending_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    logic             stall_s;
    logic             ds_ready_go_s, es_ready_go_s, ms_ready_go_s;
    logic             fs_allowin_s, ds_allowin_s, es_allowin_s, ms_allowin_s;
    logic             br_flush_s;
    fwd_sel_t         fwd_rj_s, fwd_rk_s;

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_hazard (
        .ds_rj      (bus.ds_rj),
        .ds_rk      (bus.ds_rk),
        .ds_use_rj  (bus.ds_use_rj),
        .ds_use_rk  (bus.ds_use_rk),
        .es_valid   (es_valid_r),
        .es_gr_we   (bus.es_gr_we),
        .es_load    (bus.es_load),
        .es_dest    (bus.es_dest),
        .ms_valid   (ms_valid_r),
        .ms_gr_we   (bus.ms_gr_we),
        .ms_load    (bus.ms_load),
        .ms_data_ok (bus.ms_data_ok),
        .ms_dest    (bus.ms_dest),
        .ws_valid   (ws_valid_r),
        .ws_gr_we   (bus.ws_gr_we),
        .ws_dest    (bus.ws_dest),
        .stall      (stall_s),
        .fwd_rj     (fwd_rj_s),
        .fwd_rk     (fwd_rk_s)
    );

    // WB always accepts, so the allowin chain starts at MEM.
    assign ms_ready_go_s = ~bus.ms_mem_req | bus.ms_data_ok;
    assign es_ready_go_s = ~bus.es_mem_req | bus.es_addr_ok;
    assign ds_ready_go_s = ~stall_s;
    assign ms_allowin_s  = ~ms_valid_r | ms_ready_go_s;
    assign es_allowin_s  = ~es_valid_r | (es_ready_go_s & ms_allowin_s);
    assign ds_allowin_s  = ~ds_valid_r | (ds_ready_go_s & es_allowin_s);
    assign fs_allowin_s  = ~bus.fs_valid | (bus.fs_ready_go & ds_allowin_s);
    assign br_flush_s    = ds_valid_r & ds_ready_go_s & bus.ds_br_taken & es_allowin_s;

    assign bus.fs_allowin   = fs_allowin_s;
    assign bus.ds_allowin   = ds_allowin_s;
    assign bus.es_allowin   = es_allowin_s;
    assign bus.ms_allowin   = ms_allowin_s;
    assign bus.ds_valid     = ds_valid_r;
    assign bus.es_valid     = es_valid_r;
    assign bus.ms_valid     = ms_valid_r;
    assign bus.ws_valid     = ws_valid_r;
    assign bus.fs2ds_en     = bus.fs_valid & bus.fs_ready_go & ds_allowin_s;
    assign bus.ds2es_en     = ds_valid_r & ds_ready_go_s & es_allowin_s;
    assign bus.es2ms_en     = es_valid_r & es_ready_go_s & ms_allowin_s;
    assign bus.mem_ready_go = ms_valid_r & ms_ready_go_s;
    assign bus.br_flush     = br_flush_s;
    assign bus.fwd_rj       = fwd_rj_s;
    assign bus.fwd_rk       = fwd_rk_s;
    assign bus.stall_cnt    = stall_cnt_r;
    assign bus.flush_cnt    = flush_cnt_r;

    // Stage valid registers; each advances only when its stage allows in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ds_valid_r <= 1'b0;
            es_valid_r <= 1'b0;
            ms_valid_r <= 1'b0;
            ws_valid_r <= 1'b0;
        end else begin
            if (ds_allowin_s) begin
                ds_valid_r <= bus.fs_valid & bus.fs_ready_go & ~cancel_pending_s & ~br_flush_s;
            end else begin
                ds_valid_r <= ds_valid_r;
            end
            if (es_allowin_s) begin
                es_valid_r <= ds_valid_r & ds_ready_go_s;
            end else begin
                es_valid_r <= es_valid_r;
            end
            if (ms_allowin_s) begin
                ms_valid_r <= es_valid_r & es_ready_go_s;
            end else begin
                ms_valid_r <= ms_valid_r;
            end
            ws_valid_r <= ms_valid_r & ms_ready_go_s;
        end
    end

    // Cancel state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cancel_state_r <= C_IDLE;
        end else begin
            cancel_state_r <= cancel_state_s;
        end
    end

    // A flush while the fetch is still outstanding must discard the instruction that returns next.
    always_comb begin
        cancel_state_s   = cancel_state_r;
        cancel_pending_s = 1'b0;
        case (cancel_state_r)
            C_IDLE: begin
                cancel_pending_s = 1'b0;
                if (br_flush_s & bus.fs_valid & ~bus.fs_ready_go) begin
                    cancel_state_s = C_CANCEL;
                end else begin
                    cancel_state_s = C_IDLE;
                end
            end
            C_CANCEL: begin
                cancel_pending_s = 1'b1;
                if (bus.fs_ready_go) begin
                    cancel_state_s = C_IDLE;
                end else begin
                    cancel_state_s = C_CANCEL;
                end
            end
            default: begin
                cancel_pending_s = 1'b0;
                cancel_state_s   = C_IDLE;
            end
        endcase
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (ds_valid_r & ~ds_ready_go_s) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (br_flush_s) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl, checked every cycle against a stage-array
// model of the pipeline handshake, hazard and flush rules.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();

    pipe_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: stage index 0=IF 1=ID 2=EX 3=MEM 4=WB
    logic        mv [1:4];
    logic        mcancel;
    logic [31:0] mstall;
    logic [31:0] mflush;
    // Per-cycle combinational snapshot
    logic        sv [0:4];
    logic        rg [0:4];
    logic        al [0:4];
    logic        en [0:3];
    logic        mfl;
    logic [1:0]  mfj, mfk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic writes(input int st, input logic [4:0] r);
        logic we;
        logic [4:0] d;
        case (st)
            2: begin we = bus.es_gr_we; d = bus.es_dest; end
            3: begin we = bus.ms_gr_we; d = bus.ms_dest; end
            default: begin we = bus.ws_gr_we; d = bus.ws_dest; end
        endcase
        return mv[st] && we && (d == r);
    endfunction

    function automatic logic blocks(input logic [4:0] r, input logic used);
        if (!used || r == 5'd0) return 1'b0;
        if (writes(2, r) && bus.es_load) return 1'b1;
        if (writes(3, r) && bus.ms_load && !bus.ms_data_ok) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] source_of(input logic [4:0] r);
        if (r == 5'd0) return FWD_RF;
        for (int st = 2; st <= 4; st++) begin
            if (writes(st, r)) return 2'(st - 1); // EX=1, MEM=2, WB=3
        end
        return FWD_RF;
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 4; i++) mv[i] = 1'b0;
        mcancel = 1'b0;
        mstall  = 32'd0;
        mflush  = 32'd0;
    endtask

    task automatic model_eval();
        sv[0] = bus.fs_valid;
        for (int i = 1; i <= 4; i++) sv[i] = mv[i];
        rg[0] = bus.fs_ready_go;
        rg[1] = !(blocks(bus.ds_rj, bus.ds_use_rj) || blocks(bus.ds_rk, bus.ds_use_rk));
        rg[2] = !bus.es_mem_req || bus.es_addr_ok;
        rg[3] = !bus.ms_mem_req || bus.ms_data_ok;
        rg[4] = 1'b1;
        al[4] = 1'b1;
        for (int i = 3; i >= 0; i--) al[i] = !sv[i] || (rg[i] && al[i+1]);
        for (int i = 0; i <= 3; i++) en[i] = sv[i] && rg[i] && al[i+1];
        mfl = sv[1] && rg[1] && bus.ds_br_taken && al[2];
        mfj = source_of(bus.ds_rj);
        mfk = source_of(bus.ds_rk);
    endtask

    task automatic model_update();
        for (int i = 4; i >= 1; i--) begin
            if (al[i]) mv[i] = sv[i-1] && rg[i-1] && (i != 1 || (!mcancel && !mfl));
        end
        if (!mcancel) mcancel = mfl && bus.fs_valid && !bus.fs_ready_go;
        else          mcancel = !bus.fs_ready_go;
        if (sv[1] && !rg[1]) mstall = mstall + 32'd1;
        if (mfl)             mflush = mflush + 32'd1;
    endtask

    task automatic compare_all();
        check("ds_valid", {31'd0, bus.ds_valid}, {31'd0, mv[1]});
        check("es_valid", {31'd0, bus.es_valid}, {31'd0, mv[2]});
        check("ms_valid", {31'd0, bus.ms_valid}, {31'd0, mv[3]});
        check("ws_valid", {31'd0, bus.ws_valid}, {31'd0, mv[4]});
        check("fs_allowin", {31'd0, bus.fs_allowin}, {31'd0, al[0]});
        check("ds_allowin", {31'd0, bus.ds_allowin}, {31'd0, al[1]});
        check("es_allowin", {31'd0, bus.es_allowin}, {31'd0, al[2]});
        check("ms_allowin", {31'd0, bus.ms_allowin}, {31'd0, al[3]});
        check("fs2ds_en", {31'd0, bus.fs2ds_en}, {31'd0, en[0]});
        check("ds2es_en", {31'd0, bus.ds2es_en}, {31'd0, en[1]});
        check("es2ms_en", {31'd0, bus.es2ms_en}, {31'd0, en[2]});
        check("mem_ready_go", {31'd0, bus.mem_ready_go}, {31'd0, en[3]});
        check("br_flush", {31'd0, bus.br_flush}, {31'd0, mfl});
        check("fwd_rj", {30'd0, bus.fwd_rj}, {30'd0, mfj});
        check("fwd_rk", {30'd0, bus.fwd_rk}, {30'd0, mfk});
        check("stall_cnt", bus.stall_cnt, mstall);
        check("flush_cnt", bus.flush_cnt, mflush);
    endtask

    // mode 0: fully random; mode 1: ideal ALU stream, no hazards or waits
    task automatic drive(input int mode);
        bus.ds_rj    = 5'($urandom_range(0, 7));
        bus.ds_rk    = 5'($urandom_range(0, 7));
        bus.es_dest  = 5'($urandom_range(0, 7));
        bus.ms_dest  = 5'($urandom_range(0, 7));
        bus.ws_dest  = 5'($urandom_range(0, 7));
        bus.es_gr_we = ($urandom_range(0, 3) != 0);
        bus.ms_gr_we = ($urandom_range(0, 3) != 0);
        bus.ws_gr_we = ($urandom_range(0, 3) != 0);
        if (mode == 1) begin
            bus.fs_valid    = 1'b1;
            bus.fs_ready_go = 1'b1;
            bus.ds_use_rj   = 1'b0;
            bus.ds_use_rk   = 1'b0;
            bus.ds_br_taken = 1'b0;
            bus.es_load     = 1'b0;
            bus.ms_load     = 1'b0;
            bus.es_mem_req  = 1'b0;
            bus.es_addr_ok  = 1'b0;
            bus.ms_mem_req  = 1'b0;
            bus.ms_data_ok  = 1'b0;
        end else begin
            bus.fs_valid    = ($urandom_range(0, 9) != 0);
            bus.fs_ready_go = ($urandom_range(0, 3) != 0);
            bus.ds_use_rj   = ($urandom_range(0, 1) != 0);
            bus.ds_use_rk   = ($urandom_range(0, 1) != 0);
            bus.ds_br_taken = ($urandom_range(0, 5) == 0);
            bus.es_load     = ($urandom_range(0, 2) == 0);
            bus.ms_load     = ($urandom_range(0, 2) == 0);
            bus.es_mem_req  = ($urandom_range(0, 2) == 0);
            bus.es_addr_ok  = ($urandom_range(0, 1) != 0);
            bus.ms_mem_req  = ($urandom_range(0, 2) == 0);
            bus.ms_data_ok  = ($urandom_range(0, 1) != 0);
        end
    endtask

    task automatic run_cycle(input int mode);
        drive(mode);
        #1;
        model_eval();
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        model_eval();
        compare_all();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1);
        model_reset();
        #1;
        model_eval();
        compare_all();
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int c = 0; c < 8; c++) run_cycle(1);
        check("all_valid_before_reset", {28'd0, bus.ds_valid, bus.es_valid, bus.ms_valid, bus.ws_valid}, 32'hf);
        pulse_reset();

        for (int c = 0; c < 1500; c++) run_cycle(0);
        pulse_reset();
        for (int c = 0; c < 1500; c++) run_cycle(0);
        for (int c = 0; c < 6; c++) run_cycle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
